// File: rtl/mux_n_1_stream_pkg.sv
// mux_n_1_stream_pkg: shared state encoding and default sizes for the stream mux.
package mux_n_1_stream_pkg;
   localparam int DEF_WIDTH = 2;
   localparam int DEF_N_CH  = 4;
   typedef enum logic {MUXS_IDLE = 1'b0, MUXS_LOCKED = 1'b1} state_t;
endpackage

// File: rtl/mux_n_1_stream_if.sv
// mux_n_1_stream_if: producer-side channels and consumer-side output of the stream mux.
interface mux_n_1_stream_if
   import mux_n_1_stream_pkg::*;
   #(parameter int WIDTH = DEF_WIDTH, parameter int N_CH = DEF_N_CH);
   logic [N_CH*WIDTH-1:0] in_data;
   logic [N_CH-1:0]       in_valid;
   logic [N_CH-1:0]       in_last;
   logic [N_CH-1:0]       in_ready;
   logic [WIDTH-1:0]      out_data;
   logic                  out_valid;
   logic                  out_last;
   logic                  out_ready;
   modport master (output in_data, in_valid, in_last, out_ready,
                   input in_ready, out_data, out_valid, out_last);
   modport slave (input in_data, in_valid, in_last, out_ready,
                  output in_ready, out_data, out_valid, out_last);
endinterface

// File: rtl/mux_n_1_comb.sv
// mux_n_1_comb: combinational WIDTH-bit N_CH:1 selector; out-of-range select yields zero.
module mux_n_1_comb
   import mux_n_1_stream_pkg::*;
   #(parameter int WIDTH = DEF_WIDTH, parameter int N_CH = DEF_N_CH, parameter int SEL_W = 2)
   (input  logic [N_CH*WIDTH-1:0] din,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      dout);
   always_comb begin
      dout = '0;
      for (int i = 0; i < N_CH; i++) dout = (sel == SEL_W'(i)) ? din[i*WIDTH +: WIDTH] : dout;
   end
endmodule

// File: rtl/mux_n_1_stream.sv
// mux_n_1_stream: packet-locked N_CH:1 stream mux with registered output stage.
// Optional round-robin IDLE selection under MUX_N_1_STREAM_RR_EN (adds rr_mode).
module mux_n_1_stream
   import mux_n_1_stream_pkg::*;
   #(parameter int WIDTH = DEF_WIDTH, parameter int N_CH = DEF_N_CH, parameter int SEL_W = 2)
   (input  logic             clk,
    input  logic             reset_L,
    mux_n_1_stream_if.slave  s,
`ifdef MUX_N_1_STREAM_RR_EN
    input  logic             rr_mode,
`endif
    input  logic [SEL_W-1:0] sel,
    output logic [SEL_W-1:0] active_ch,
    output logic             err_sel);
   state_t           state, state_nx;
   logic             ld, sel_ok, pick_ok, xfer, rr, rr_hit, mux_last;
   logic [SEL_W-1:0] eff_ch, rr_ch;
   logic [WIDTH-1:0] mux_data;
`ifdef MUX_N_1_STREAM_RR_EN
   assign rr = rr_mode;
   // Descending distance so the nearest valid channel after active_ch wins.
   always_comb begin
      rr_ch  = active_ch;
      rr_hit = 1'b0;
      for (int k = N_CH; k >= 1; k--)
         for (int i = 0; i < N_CH; i++)
            if ((int'(active_ch) + k) % N_CH == i && s.in_valid[i]) begin
               rr_ch  = SEL_W'(i);
               rr_hit = 1'b1;
            end
   end
`else
   assign rr     = 1'b0;
   assign rr_ch  = '0;
   assign rr_hit = 1'b0;
`endif
   always_comb begin
      ld       = !s.out_valid || s.out_ready;
      sel_ok   = int'(sel) < N_CH;
      eff_ch   = (state == MUXS_LOCKED) ? active_ch : rr ? rr_ch : sel;
      pick_ok  = (state == MUXS_LOCKED) || (rr ? rr_hit : sel_ok);
      s.in_ready = '0;
      for (int i = 0; i < N_CH; i++) s.in_ready[i] = reset_L && ld && pick_ok && eff_ch == SEL_W'(i);
      xfer     = |(s.in_ready & s.in_valid);
      state_nx = xfer ? (mux_last ? MUXS_IDLE : MUXS_LOCKED) : state;
   end
   mux_n_1_comb #(.WIDTH(WIDTH), .N_CH(N_CH), .SEL_W(SEL_W)) u_data
      (.din(s.in_data), .sel(eff_ch), .dout(mux_data));
   mux_n_1_comb #(.WIDTH(1), .N_CH(N_CH), .SEL_W(SEL_W)) u_last
      (.din(s.in_last), .sel(eff_ch), .dout(mux_last));
   always_ff @(posedge clk or negedge reset_L)
      if (!reset_L) state <= MUXS_IDLE;
      else state <= state_nx;
   always_ff @(posedge clk or negedge reset_L)
      if (!reset_L) begin
         active_ch   <= '0;
         err_sel     <= 1'b0;
         s.out_data  <= '0;
         s.out_valid <= 1'b0;
         s.out_last  <= 1'b0;
      end else begin
         if (xfer) begin
            active_ch   <= eff_ch;
            s.out_data  <= mux_data;
            s.out_last  <= mux_last;
            s.out_valid <= 1'b1;
         end else if (s.out_ready) s.out_valid <= 1'b0;
         if (state == MUXS_IDLE && !rr && !sel_ok) err_sel <= 1'b1;
      end
endmodule

// File: tb/tb_mux_n_1_stream.sv
// tb_mux_n_1_stream: directed and random stimulus against a packet-level model plus beat scoreboard.
module tb_mux_n_1_stream;
   localparam int W = 2, N = 3, SW = 2;
   logic clk = 0, reset_L = 0, rr_mode = 0;
   logic [SW-1:0] sel = '0, active_ch;
   logic err_sel;
   int total = 0, bad = 0;
   logic [W:0] q[$];
   bit m_locked, m_err, m_ov, m_ol, m_ld, ok;
   int m_ch, ch;
   logic [W-1:0] m_od;
   logic [N-1:0] exp_rdy;
   logic [W:0] e;
   mux_n_1_stream_if #(.WIDTH(W), .N_CH(N)) bus();
   mux_n_1_stream #(.WIDTH(W), .N_CH(N), .SEL_W(SW)) dut
      (.clk(clk), .reset_L(reset_L), .s(bus),
`ifdef MUX_N_1_STREAM_RR_EN
       .rr_mode(rr_mode),
`endif
       .sel(sel), .active_ch(active_ch), .err_sel(err_sel));
   always #5 clk = ~clk;
   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask
   task automatic model_reset();
      m_locked = 0; m_err = 0; m_ov = 0; m_ol = 0; m_od = '0; m_ch = 0;
      q.delete();
   endtask
   task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic [N*W-1:0] d,
                        input logic [SW-1:0] s, input logic r);
      bus.in_valid = v; bus.in_last = l; bus.in_data = d; sel = s; bus.out_ready = r;
      @(posedge clk); #1;
   endtask
   // Reference model: which channel the spec allows to be accepted this cycle.
   always @(negedge clk) if (reset_L) begin
      m_ld = !m_ov || bus.out_ready;
      ch = 0; ok = 0;
      if (m_locked) begin ch = m_ch; ok = 1; end
      else if (rr_mode) begin
         for (int k = 1; k <= N; k++)
            if (!ok && bus.in_valid[2'((m_ch + k) % N)]) begin ch = (m_ch + k) % N; ok = 1; end
      end else begin ch = int'(sel); ok = ch < N; end
      exp_rdy = (m_ld && ok) ? N'(1 << ch) : '0;
      chk("in_ready", int'(bus.in_ready), int'(exp_rdy));
      chk("out_valid", int'(bus.out_valid), int'(m_ov));
      if (m_ov) begin
         chk("out_data", int'(bus.out_data), int'(m_od));
         chk("out_last", int'(bus.out_last), int'(m_ol));
      end
      chk("active_ch", int'(active_ch), m_ch);
      chk("err_sel", int'(err_sel), int'(m_err));
      if (!m_locked && !rr_mode && !ok) m_err = 1;
      if (ok && m_ld && bus.in_valid[2'(ch)]) begin
         m_od = W'(bus.in_data >> (ch * W));
         m_ol = bus.in_last[2'(ch)];
         m_ov = 1; m_ch = ch; m_locked = !m_ol;
         q.push_back({m_ol, m_od});
      end else if (bus.out_ready) m_ov = 0;
   end
   // Scoreboard: every accepted beat must leave exactly once, in order.
   always @(negedge clk) if (reset_L && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) chk("sb_empty", 1, 0);
      else begin
         e = q.pop_front();
         chk("sb_beat", int'({bus.out_last, bus.out_data}), int'(e));
      end
   end
   initial begin
      model_reset();
      bus.in_valid = '1; bus.in_last = '0; bus.in_data = '0; bus.out_ready = 1;
      #1;
      chk("rst_in_ready", int'(bus.in_ready), 0);
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_out_data", int'(bus.out_data), 0);
      chk("rst_active_ch", int'(active_ch), 0);
      chk("rst_err_sel", int'(err_sel), 0);
      @(posedge clk); #1;
      reset_L = 1;
      drive(3'b100, 3'b100, 6'b10_00_00, 2, 1);
      chk("single_data", int'(bus.out_data), 2);
      chk("single_last", int'(bus.out_last), 1);
      drive(3'b010, 3'b000, 6'b00_01_00, 1, 1);
      chk("lock_ch", int'(active_ch), 1);
      drive(3'b110, 3'b000, 6'b11_10_00, 2, 1);
      drive(3'b110, 3'b010, 6'b11_11_00, 2, 1);
      chk("lock_last", int'(bus.out_last), 1);
      drive(3'b100, 3'b100, 6'b01_00_00, 2, 1);
      chk("after_lock_ch", int'(active_ch), 2);
      drive(3'b001, 3'b000, 6'b00_00_01, 0, 1);
      for (int i = 0; i < 4; i++) drive(3'b001, 3'b000, 6'b00_00_10, 0, 0);
      chk("bp_data", int'(bus.out_data), 1);
      drive(3'b001, 3'b000, 6'b00_00_10, 0, 1);
      drive(3'b001, 3'b000, 6'b00_00_11, 0, 1);
      drive(3'b001, 3'b001, 6'b00_00_00, 0, 1);
      drive(3'b111, 3'b111, 6'b11_11_11, 3, 1);
      drive(3'b111, 3'b111, 6'b11_11_11, 3, 1);
      chk("bad_sel_err", int'(err_sel), 1);
      drive(3'b001, 3'b001, 6'b00_00_10, 0, 1);
      chk("bad_sel_recover", int'(bus.out_data), 2);
      chk("err_sticky", int'(err_sel), 1);
      drive(3'b010, 3'b000, 6'b00_11_00, 1, 1);
      reset_L = 0;
      #1;
      chk("mid_rst_out_valid", int'(bus.out_valid), 0);
      chk("mid_rst_active_ch", int'(active_ch), 0);
      chk("mid_rst_err", int'(err_sel), 0);
      model_reset();
      @(posedge clk); #1;
      reset_L = 1;
`ifdef MUX_N_1_STREAM_RR_EN
      rr_mode = 1;
      for (int i = 1; i <= N; i++) begin
         drive(3'b111, 3'b111, 6'b10_01_11, 0, 1);
         chk("rr_order", int'(active_ch), i % N);
      end
      drive(3'b000, 3'b000, 6'b00_00_00, 0, 1);
`endif
      for (int i = 0; i < 3000; i++) begin
`ifdef MUX_N_1_STREAM_RR_EN
         if (i % 200 == 0) rr_mode = 1'($urandom);
`endif
         drive(N'($urandom), N'($urandom_range(0, 3) == 0 ? $urandom : 0),
               (N*W)'($urandom), SW'($urandom_range(0, 11) == 0 ? 3 : $urandom_range(0, 2)),
               1'($urandom_range(0, 9) < 7));
      end
      for (int i = 0; i < 3; i++) drive(3'b000, 3'b000, 6'b00_00_00, 0, 1);
      chk("drain", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
